// File: rtl/noc_inject_arbiter.sv
// Credit-gated N:1 flit injection mux for router port 0.
// Arbitration is round-robin per packet, and a packet holds the output until its tail flit is sent.
//
// state  | meaning
// IDLE   | no packet owns the output; the next valid channel after rr_ptr is granted
// LOCKED | channel lock_ch is mid-packet and is the only channel allowed to send
module noc_inject_arbiter #(
   parameter int NUM_CHANNELS      = 4,
   parameter int FLIT_WIDTH        = 32,
   parameter int DEST_WIDTH        = 6,
   parameter int FLIT_BUFFER_DEPTH = 4,
   parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                                       clk_noc,
   input  logic                                       rst_noc,
   input  logic [0:NUM_CHANNELS-1][FLIT_WIDTH-1:0]    ch_data_in,
   input  logic [0:NUM_CHANNELS-1][DEST_WIDTH-1:0]    ch_dest_in,
   input  logic [0:NUM_CHANNELS-1]                    ch_is_tail_in,
   input  logic [0:NUM_CHANNELS-1]                    ch_valid,
   output logic [0:NUM_CHANNELS-1]                    ch_ready,
   output logic [FLIT_WIDTH-1:0]                      data_out,
   output logic [DEST_WIDTH-1:0]                      dest_out,
   output logic                                       is_tail_out,
   output logic                                       send_out,
   input  logic                                       credit_in,
   output logic [CREDIT_WIDTH-1:0]                    credit_count,
   output logic                                       err_credit_overflow
);

   localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [CH_W-1:0]         LAST_CH    = CH_W'(NUM_CHANNELS - 1);
   localparam logic [CREDIT_WIDTH-1:0] FULL_CRED  = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
   localparam logic [CREDIT_WIDTH-1:0] ONE_CRED   = CREDIT_WIDTH'(1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0] lock_ch_q, lock_ch_d;
   logic [CH_W-1:0] grant_ch;
   logic [CH_W-1:0] sel_ch;
   logic            grant_found;
   logic            have_credit;
   logic            accept;
   logic            sel_tail;

   // Search upward from the channel after rr_ptr, wrapping at NUM_CHANNELS.
   always_comb begin : rr_search
      int              idx;
      logic [CH_W-1:0] cand;
      idx         = 0;
      cand        = '0;
      grant_ch    = '0;
      grant_found = 1'b0;
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         cand = CH_W'(idx);
         if (!grant_found && ch_valid[cand]) begin
            grant_found = 1'b1;
            grant_ch    = cand;
         end
      end
   end

   assign sel_ch      = (state_q == LOCKED) ? lock_ch_q : grant_ch;
   assign have_credit = (credit_count != '0);
   assign accept      = ch_valid[sel_ch] & ch_ready[sel_ch];
   assign sel_tail    = ch_is_tail_in[sel_ch];

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      lock_ch_d = lock_ch_q;
      ch_ready  = '0;
      // Gate on the registered count only, so credit_in never reaches ch_ready.
      if (!rst_noc && have_credit && ((state_q == LOCKED) || grant_found))
         ch_ready[sel_ch] = 1'b1;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rr_ptr_d = sel_ch;
               if (!sel_tail) begin
                  state_d   = LOCKED;
                  lock_ch_d = sel_ch;
               end
            end
         end
         LOCKED: begin
            if (accept && sel_tail) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         state_q   <= IDLE;
         rr_ptr_q  <= LAST_CH;
         lock_ch_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         lock_ch_q <= lock_ch_d;
      end
   end

   // A credit arriving with the buffer already full saturates and latches the error.
   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         credit_count        <= FULL_CRED;
         err_credit_overflow <= 1'b0;
      end else if (accept && !credit_in) begin
         credit_count <= credit_count - ONE_CRED;
      end else if (credit_in && !accept) begin
         if (credit_count == FULL_CRED) err_credit_overflow <= 1'b1;
         else                           credit_count        <= credit_count + ONE_CRED;
      end
   end

   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         send_out    <= 1'b0;
         data_out    <= '0;
         dest_out    <= '0;
         is_tail_out <= 1'b0;
      end else begin
         send_out <= accept;
         if (accept) begin
            data_out    <= ch_data_in[sel_ch];
            dest_out    <= ch_dest_in[sel_ch];
            is_tail_out <= sel_tail;
         end
      end
   end

endmodule
